// File: rtl/seven_seg_pkg.sv
// Shared types and constants for the 7-segment scan controller.
package seven_seg_pkg;

   typedef enum logic [1:0] {IDLE, BLANK, SHOW} state_e;

   localparam logic [7:0]  CATHODE_BLANK = 8'hFF;
   localparam logic [31:0] ANODE_OFF     = '1;

endpackage

// File: rtl/seven_seg_scan_ctrl_if.sv
// Display-word load channel (valid/ready) into the scan controller.
interface seven_seg_scan_ctrl_if #(parameter int NUM_DIGITS = 8);

   logic [4*NUM_DIGITS-1:0] digits_in;
   logic [NUM_DIGITS-1:0]   dp_in;
   logic [NUM_DIGITS-1:0]   den_in;
   logic                    lzs_in;
   logic                    load_valid;
   logic                    load_ready;

   modport master (output digits_in, dp_in, den_in, lzs_in, load_valid, input load_ready);
   modport slave  (input digits_in, dp_in, den_in, lzs_in, load_valid, output load_ready);

endinterface

// File: rtl/seven_seg_decoder.sv
// BCD to active-low {dp,g..a}; values 10..15 leave all segments off.
module seven_seg_decoder (
   input  logic [3:0] number,
   input  logic       dec_point,
   output logic [7:0] cathode
);

   logic [6:0] seg;

   always_comb begin
      seg = 7'h7F;
      case (number)
         4'd0: seg = 7'h40;
         4'd1: seg = 7'h79;
         4'd2: seg = 7'h24;
         4'd3: seg = 7'h30;
         4'd4: seg = 7'h19;
         4'd5: seg = 7'h12;
         4'd6: seg = 7'h02;
         4'd7: seg = 7'h78;
         4'd8: seg = 7'h00;
         4'd9: seg = 7'h10;
         default: seg = 7'h7F;
      endcase
      cathode = {~dec_point, seg};
   end

endmodule

// File: rtl/seven_seg_scan_ctrl.sv
// Multiplexed scan of NUM_DIGITS common-anode digits with a double-buffered,
// frame-synchronous display word so updates never tear mid-frame.
module seven_seg_scan_ctrl
   import seven_seg_pkg::*;
#(
   parameter int NUM_DIGITS  = 8,
   parameter int DIGIT_TICKS = 100000,
   parameter int BLANK_TICKS = 2000
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  enable,
   seven_seg_scan_ctrl_if.slave  ld,
   output logic [NUM_DIGITS-1:0] anode,
   output logic [7:0]            cathode,
   output logic                  frame_tick
);

   localparam int CW = $clog2(DIGIT_TICKS);
   localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
   localparam logic [CW-1:0] BLANK_END = CW'(BLANK_TICKS - 1);
   localparam logic [CW-1:0] SLOT_END  = CW'(DIGIT_TICKS - 1);
   localparam logic [IW-1:0] LAST_IDX  = IW'(NUM_DIGITS - 1);

   state_e                  state_q, state_d;
   logic [CW-1:0]           cnt_q, cnt_d;
   logic [IW-1:0]           idx_q, idx_d;
   logic                    frame_end;

   logic [4*NUM_DIGITS-1:0] act_dig_q, pend_dig_q;
   logic [NUM_DIGITS-1:0]   act_dp_q, pend_dp_q, act_den_q, pend_den_q;
   logic                    act_lzs_q, pend_lzs_q, pend_full_q;
   logic                    accept;

   logic [NUM_DIGITS-1:0]   anode_q, anode_d, lzs_mask;
   logic [7:0]              cathode_q, cathode_d, dec_cathode;
   logic                    ftick_q;
   logic                    sup;
   logic [3:0]              cur_num;
   logic                    cur_dp;

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      idx_d     = idx_q;
      frame_end = 1'b0;
      if (!enable) begin
         state_d = IDLE;
         cnt_d   = '0;
         idx_d   = '0;
      end else begin
         case (state_q)
            IDLE: begin
               state_d = BLANK;
               cnt_d   = '0;
               idx_d   = '0;
            end
            BLANK: begin
               cnt_d = cnt_q + 1'b1;
               if (cnt_q == BLANK_END) state_d = SHOW;
            end
            SHOW: begin
               if (cnt_q == SLOT_END) begin
                  cnt_d   = '0;
                  state_d = BLANK;
                  if (idx_q == LAST_IDX) begin
                     idx_d     = '0;
                     frame_end = 1'b1;
                  end else begin
                     idx_d = idx_q + 1'b1;
                  end
               end else begin
                  cnt_d = cnt_q + 1'b1;
               end
            end
            default: state_d = IDLE;
         endcase
      end
   end

   // A digit is zero-suppressed only while every digit above it is too.
   always_comb begin
      sup      = 1'b1;
      lzs_mask = '0;
      for (int i = NUM_DIGITS - 1; i > 0; i--) begin
         sup         = sup & act_lzs_q & (act_dig_q[4*i +: 4] == 4'd0) & ~act_dp_q[i];
         lzs_mask[i] = sup;
      end
   end

   assign cur_num = act_dig_q[4*idx_q +: 4];
   assign cur_dp  = act_dp_q[idx_q];

   seven_seg_decoder u_dec (
      .number    (cur_num),
      .dec_point (cur_dp),
      .cathode   (dec_cathode)
   );

   always_comb begin
      anode_d   = ANODE_OFF[NUM_DIGITS-1:0];
      cathode_d = CATHODE_BLANK;
      if (state_q == SHOW) begin
         anode_d[idx_q] = 1'b0;
         if (act_den_q[idx_q] && !lzs_mask[idx_q]) cathode_d = dec_cathode;
      end
   end

   assign accept = ld.load_valid & ~pend_full_q;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q   <= IDLE;
         cnt_q     <= '0;
         idx_q     <= '0;
         anode_q   <= ANODE_OFF[NUM_DIGITS-1:0];
         cathode_q <= CATHODE_BLANK;
         ftick_q   <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         idx_q     <= idx_d;
         anode_q   <= anode_d;
         cathode_q <= cathode_d;
         ftick_q   <= frame_end;
      end
   end

   // Accept needs pending empty and swap needs it full, so they never coincide.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         act_dig_q   <= '0;
         act_dp_q    <= '0;
         act_den_q   <= '0;
         act_lzs_q   <= 1'b0;
         pend_dig_q  <= '0;
         pend_dp_q   <= '0;
         pend_den_q  <= '0;
         pend_lzs_q  <= 1'b0;
         pend_full_q <= 1'b0;
      end else begin
         if (frame_end && pend_full_q) begin
            act_dig_q   <= pend_dig_q;
            act_dp_q    <= pend_dp_q;
            act_den_q   <= pend_den_q;
            act_lzs_q   <= pend_lzs_q;
            pend_full_q <= 1'b0;
         end
         if (accept) begin
            pend_dig_q  <= ld.digits_in;
            pend_dp_q   <= ld.dp_in;
            pend_den_q  <= ld.den_in;
            pend_lzs_q  <= ld.lzs_in;
            pend_full_q <= 1'b1;
         end
      end
   end

   assign ld.load_ready = ~pend_full_q;
   assign anode         = anode_q;
   assign cathode       = cathode_q;
   assign frame_tick    = ftick_q;

endmodule

// File: tb/tb_seven_seg_scan_ctrl.sv
// Randomized bench for seven_seg_scan_ctrl against a positional scan model.
module tb_seven_seg_scan_ctrl;

   localparam int N  = 4;
   localparam int DT = 8;
   localparam int BT = 2;
   localparam int FR = N * DT;

   typedef struct packed {
      logic [15:0] dig;
      logic [3:0]  dp;
      logic [3:0]  den;
      logic        lzs;
   } word_t;

   logic         clk = 1'b0;
   logic         reset = 1'b1;
   logic         enable = 1'b0;
   logic [N-1:0] anode;
   logic [7:0]   cathode;
   logic         frame_tick;

   seven_seg_scan_ctrl_if #(.NUM_DIGITS(N)) ld();

   seven_seg_scan_ctrl #(.NUM_DIGITS(N), .DIGIT_TICKS(DT), .BLANK_TICKS(BT)) dut (
      .clk        (clk),
      .reset      (reset),
      .enable     (enable),
      .ld         (ld),
      .anode      (anode),
      .cathode    (cathode),
      .frame_tick (frame_tick)
   );

   always #5 clk = ~clk;

   // model: m_pos = cycles into the current frame while scanning
   word_t        m_act, m_pend;
   bit           m_full, m_run, m_acc;
   int           m_pos;
   logic [N-1:0] e_an;
   logic [7:0]   e_ca;
   logic         e_ft, e_rdy;
   int           n_cmp = 0;
   int           n_bad = 0;

   function automatic logic [7:0] seg_of(logic [3:0] v, logic dp);
      logic [7:0] s;
      case (v)
         4'd0: s = 8'hC0;  4'd1: s = 8'hF9;  4'd2: s = 8'hA4;  4'd3: s = 8'hB0;
         4'd4: s = 8'h99;  4'd5: s = 8'h92;  4'd6: s = 8'h82;  4'd7: s = 8'hF8;
         4'd8: s = 8'h80;  4'd9: s = 8'h90;  default: s = 8'hFF;
      endcase
      if (dp) s[7] = 1'b0;
      return s;
   endfunction

   function automatic logic [7:0] exp_cath(word_t w, int slot);
      bit zeros_above;
      if (!w.den[slot]) return 8'hFF;
      if (w.lzs && slot != 0) begin
         zeros_above = 1'b1;
         for (int j = slot; j < N; j++)
            if (w.dig[4*j +: 4] != 4'd0 || w.dp[j]) zeros_above = 1'b0;
         if (zeros_above) return 8'hFF;
      end
      return seg_of(w.dig[4*slot +: 4], w.dp[slot]);
   endfunction

   task automatic model_reset();
      m_act = '0; m_pend = '0; m_full = 0; m_run = 0; m_pos = 0; m_acc = 0;
      e_an = '1; e_ca = 8'hFF; e_ft = 1'b0; e_rdy = 1'b1;
   endtask

   task automatic drive(word_t w, logic v);
      ld.digits_in = w.dig; ld.dp_in = w.dp; ld.den_in = w.den; ld.lzs_in = w.lzs;
      ld.load_valid = v;
   endtask

   // Advances one clock and the model; pins lag the scan position by one cycle.
   task automatic tick();
      bit fe;
      @(posedge clk);
      m_acc = 1'b0;
      if (reset) model_reset();
      else begin
         e_an = '1; e_ca = 8'hFF;
         if (m_run && (m_pos % DT) >= BT) begin
            e_an = ~(4'b0001 << (m_pos / DT));
            e_ca = exp_cath(m_act, m_pos / DT);
         end
         fe   = enable && m_run && m_pos == FR - 1;
         e_ft = fe;
         m_acc = ld.load_valid && !m_full;
         if (fe && m_full) begin m_act = m_pend; m_full = 0; end
         if (m_acc) begin
            m_pend = '{dig: ld.digits_in, dp: ld.dp_in, den: ld.den_in, lzs: ld.lzs_in};
            m_full = 1;
         end
         if (!enable) begin m_run = 0; m_pos = 0; end
         else if (!m_run) begin m_run = 1; m_pos = 0; end
         else m_pos = (m_pos + 1) % FR;
         e_rdy = !m_full;
      end
      #1;
   endtask

   task automatic test_reset();
      model_reset();
      drive('0, 1'b0);
      repeat (2) tick();
      n_cmp++;
      if ({anode, cathode, frame_tick, ld.load_ready} !== {4'hF, 8'hFF, 1'b0, 1'b1}) begin
         n_bad++;
         $display("FAIL reset: got an=%h ca=%h ft=%b rdy=%b want an=F ca=FF ft=0 rdy=1",
                  anode, cathode, frame_tick, ld.load_ready);
      end
      reset = 1'b0;
   endtask

   task automatic test_basic();
      word_t w = '{dig: 16'h4321, dp: 4'h0, den: 4'hF, lzs: 1'b0};
      logic [7:0] want;
      drive(w, 1'b1);
      enable = 1'b1;
      for (int c = 0; c < 4 * FR; c++) begin
         tick();
         if (m_acc) ld.load_valid = 1'b0;
         n_cmp++;
         if ({anode, cathode, frame_tick, ld.load_ready} !== {e_an, e_ca, e_ft, e_rdy}) begin
            n_bad++;
            $display("FAIL basic: got an=%h ca=%h ft=%b rdy=%b want an=%h ca=%h ft=%b rdy=%b",
                     anode, cathode, frame_tick, ld.load_ready, e_an, e_ca, e_ft, e_rdy);
         end
         if (c >= 2 * FR && anode != 4'hF) begin
            case (anode)
               4'hE: want = 8'hF9;  4'hD: want = 8'hA4;
               4'hB: want = 8'hB0;  default: want = 8'h99;
            endcase
            n_cmp++;
            if (cathode !== want) begin
               n_bad++;
               $display("FAIL basic_digit: an=%h got ca=%h want ca=%h", anode, cathode, want);
            end
         end
      end
   endtask

   task automatic test_reset_mid();
      word_t w = '{dig: 16'h9876, dp: 4'h1, den: 4'hF, lzs: 1'b0};
      drive(w, 1'b1);
      for (int c = 0; c < 3 * FR && !(m_full && m_run && (m_pos % DT) == 4); c++) begin
         tick();
         if (m_acc) ld.load_valid = 1'b0;
      end
      #2 reset = 1'b1;
      #1;
      n_cmp++;
      if ({anode, cathode, frame_tick, ld.load_ready} !== {4'hF, 8'hFF, 1'b0, 1'b1}) begin
         n_bad++;
         $display("FAIL reset_mid: got an=%h ca=%h ft=%b rdy=%b want an=F ca=FF ft=0 rdy=1",
                  anode, cathode, frame_tick, ld.load_ready);
      end
      enable = 1'b0;
      tick();
      reset = 1'b0;
   endtask

   task automatic test_lzs();
      word_t w = '{dig: 16'h0050, dp: 4'h0, den: 4'hF, lzs: 1'b1};
      enable = 1'b1;
      for (int k = 0; k < 2; k++) begin
         if (k == 1) w.dp = 4'h8;
         drive(w, 1'b1);
         for (int c = 0; c < 3 * FR; c++) begin
            tick();
            if (m_acc) ld.load_valid = 1'b0;
            n_cmp++;
            if ({anode, cathode, frame_tick, ld.load_ready} !== {e_an, e_ca, e_ft, e_rdy}) begin
               n_bad++;
               $display("FAIL lzs%0d: got an=%h ca=%h ft=%b rdy=%b want an=%h ca=%h ft=%b rdy=%b",
                        k, anode, cathode, frame_tick, ld.load_ready, e_an, e_ca, e_ft, e_rdy);
            end
         end
      end
   endtask

   task automatic test_back_to_back();
      word_t a = '{dig: 16'h1357, dp: 4'h2, den: 4'hF, lzs: 1'b0};
      word_t b = '{dig: 16'h8642, dp: 4'h4, den: 4'hF, lzs: 1'b0};
      int budget = 0;
      while (!(m_run && m_pos == FR / 2) && budget < 2 * FR) begin tick(); budget++; end
      drive(a, 1'b1);
      tick();
      if (m_acc) drive(b, 1'b1);
      budget = 0;
      while (!m_acc && budget < 3 * FR) begin
         n_cmp++;
         if ({anode, cathode, frame_tick, ld.load_ready} !== {e_an, e_ca, e_ft, e_rdy}) begin
            n_bad++;
            $display("FAIL b2b_stall: got an=%h ca=%h ft=%b rdy=%b want an=%h ca=%h ft=%b rdy=%b",
                     anode, cathode, frame_tick, ld.load_ready, e_an, e_ca, e_ft, e_rdy);
         end
         tick();
         budget++;
      end
      n_cmp++;
      if (!m_acc) begin
         n_bad++;
         $display("FAIL b2b_timeout: got no accept of B want accept within %0d cycles", 3 * FR);
      end
      ld.load_valid = 1'b0;
      for (int c = 0; c < 2 * FR; c++) begin
         tick();
         n_cmp++;
         if ({anode, cathode, frame_tick, ld.load_ready} !== {e_an, e_ca, e_ft, e_rdy}) begin
            n_bad++;
            $display("FAIL b2b_run: got an=%h ca=%h ft=%b rdy=%b want an=%h ca=%h ft=%b rdy=%b",
                     anode, cathode, frame_tick, ld.load_ready, e_an, e_ca, e_ft, e_rdy);
         end
      end
   endtask

   task automatic test_enable_drop();
      int budget = 0;
      while (!(m_run && m_pos / DT == 2 && m_pos % DT == 4) && budget < 2 * FR) begin
         tick(); budget++;
      end
      enable = 1'b0;
      for (int c = 0; c < 2 * FR + 6; c++) begin
         if (c == 6) enable = 1'b1;
         tick();
         n_cmp++;
         if ({anode, cathode, frame_tick, ld.load_ready} !== {e_an, e_ca, e_ft, e_rdy}) begin
            n_bad++;
            $display("FAIL enable_drop: got an=%h ca=%h ft=%b rdy=%b want an=%h ca=%h ft=%b rdy=%b",
                     anode, cathode, frame_tick, ld.load_ready, e_an, e_ca, e_ft, e_rdy);
         end
      end
   endtask

   task automatic test_den();
      word_t w = '{dig: 16'h7C35, dp: 4'h0, den: 4'b1010, lzs: 1'b0};
      for (int k = 0; k < 2; k++) begin
         if (k == 1) begin w.den = 4'hF; w.dp = 4'h4; end
         drive(w, 1'b1);
         for (int c = 0; c < 3 * FR; c++) begin
            tick();
            if (m_acc) ld.load_valid = 1'b0;
            n_cmp++;
            if ({anode, cathode, frame_tick, ld.load_ready} !== {e_an, e_ca, e_ft, e_rdy}) begin
               n_bad++;
               $display("FAIL den%0d: got an=%h ca=%h ft=%b rdy=%b want an=%h ca=%h ft=%b rdy=%b",
                        k, anode, cathode, frame_tick, ld.load_ready, e_an, e_ca, e_ft, e_rdy);
            end
         end
      end
   endtask

   task automatic test_random();
      word_t w;
      for (int r = 0; r < 40; r++) begin
         w.dig = 16'($urandom);
         if ($urandom_range(1, 0) == 1) w.dig[15:8] = 8'h00;
         w.dp  = 4'($urandom) & 4'($urandom);
         w.lzs = 1'($urandom);
         w.den = w.lzs ? 4'hF : 4'($urandom);
         drive(w, $urandom_range(3, 0) != 0);
         for (int c = 0; c < $urandom_range(50, 10); c++) begin
            if ($urandom_range(60, 0) == 0) enable = ~enable;
            tick();
            if (m_acc) ld.load_valid = 1'b0;
            n_cmp++;
            if ({anode, cathode, frame_tick, ld.load_ready} !== {e_an, e_ca, e_ft, e_rdy}) begin
               n_bad++;
               $display("FAIL random: got an=%h ca=%h ft=%b rdy=%b want an=%h ca=%h ft=%b rdy=%b",
                        anode, cathode, frame_tick, ld.load_ready, e_an, e_ca, e_ft, e_rdy);
            end
         end
         enable = 1'b1;
      end
   endtask

   initial begin
      drive('0, 1'b0);
      test_reset();
      test_basic();
      test_reset_mid();
      test_lzs();
      test_back_to_back();
      test_enable_drop();
      test_den();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
